fm_tile_router: RTL and testbench
=================================

FM_TILE_ROUTER -- requirements
Module: fm_tile_router

Interface
REQ-001 Parameter POX, default 32, output lanes (output pixels per beat).
REQ-002 Parameter DW, default 8, pixel width in bits.
REQ-003 Ports: clk  in  1  sole clock, rising edge.
REQ-004 Ports: rst  in  1  reset, synchronous, active-high.
REQ-005 Ports: set in 1 config load strobe; k_set, stride_set, pad_set, ox_set, oy_set, ix_set, iy_set in 8 each, latched on set.
REQ-006 Ports: start in 1 begin walk; busy out 1 walk in progress; cfg_err out 1 latched config invalid.
REQ-007 Ports: rd_en out 1 row read request; rd_row out 12 signed input row; rd_col out 12 signed base column; rd_data in 2*POX*DW, pixel j at bits [j*DW +: DW], valid exactly 1 cycle after rd_en.
REQ-008 Ports: out_valid out 1; out_ready in 1; out_data out POX*DW, lane p at [p*DW +: DW]; out_first out 1 first tap (ky=0,kx=0); out_last_k out 1 last tap; out_last out 1 final beat of walk.

Function
REQ-009 set SHALL load config only when busy=0; ignored while busy=1.
REQ-010 cfg_err SHALL be 1 after a load when stride not in {1,2}, k=0, ox=0 or oy=0; start SHALL be ignored while cfg_err=1.
REQ-011 start with busy=0, cfg_err=0 SHALL move IDLE->FETCH next cycle and set busy=1; start while busy ignored.
REQ-012 Walk order, outermost first: oy_r 0..oy-1, tile t 0..ceil(ox/POX)-1, ky 0..k-1, kx 0..k-1; one output beat per combination.
REQ-013 Per beat: row = oy_r*stride+ky-pad; col = t*POX*stride+kx-pad; 12-bit signed arithmetic, no overflow for 8-bit config.
REQ-014 FETCH: row in [0,iy-1] -> rd_en=1 one cycle with rd_row=row, rd_col=col, go WAIT; else no rd_en, go EMIT with all lanes zero.
REQ-015 WAIT: capture rd_data next cycle, go EMIT.
REQ-016 Lane p SHALL be pixel j=p*stride of rd_data, forced zero if col+j<0, col+j>=ix, or t*POX+p>=ox.
REQ-017 EMIT: out_valid=1; out_data/out_first/out_last_k/out_last stable until out_valid&&out_ready; then FETCH for next beat, or IDLE with busy=0 after last beat.
REQ-018 Max throughput: one beat per 3 cycles with rd_en, 2 cycles for padded rows; out_ready held low stalls indefinitely with no lost or repeated beat.
REQ-019 out_last=1 only on beat (oy-1, last tile, k-1, k-1); out_first/out_last_k per tap regardless of row padding.
REQ-020 ox not a multiple of POX: final tile zeroes upper lanes (REQ-016), beat count unchanged.

Reset
REQ-021 rst SHALL force IDLE; busy, rd_en, out_valid, out_first, out_last_k, out_last, cfg_err = 0; out_data = 0; config registers = 0; rst beats set and start in same cycle.
REQ-022 rst mid-walk SHALL abort with no further rd_en or out_valid; next start restarts at beat 0.

Configuration
REQ-023 Macro FM_ROUTER_LANE_MASK_EN defined: extra port out_mask out POX, bit p=1 iff lane p not forced zero by REQ-016, valid with out_valid; undefined: port absent, all else identical.

Verification (POX=4, DW=8, rd_data pixel j of row r at col c = r*16+c+1)
REQ-024 k=3,s=1,pad=1,ix=iy=ox=oy=4, start, out_ready=1 -> 36 beats; beat 0 zeros, no rd_en, out_first=1; beat 3 (ky=1,kx=0) rd_row=0, rd_col=-1, lanes {0,1,2,3}; out_last only on beat 35.
REQ-025 k=1,s=2,pad=0,ix=iy=8,ox=oy=4 -> 4 beats; beat 0 rd_col=0, lanes {1,3,5,7}.
REQ-026 k=1,s=1,pad=0,ix=iy=6,ox=6,oy=1 -> 2 beats; beat 1 rd_col=4, lanes {5,6,0,0}, out_mask=0011 when macro set.
REQ-027 out_ready low for 5 cycles in EMIT -> out_data constant, single handshake, rd_en not reasserted.
REQ-028 stride_set=3 -> cfg_err=1, start ignored; rst asserted on beat 10 of REQ-024 -> idle next cycle, restart yields 36 beats.

Source files
------------

// File: rtl/fm_tile_router.sv
// Feature-map tile router: walks output rows, POX-wide tiles and kernel taps,
// fetches one padded input row segment per tap and emits strided, masked lanes.
// Optional lane-mask output enabled by defining FM_ROUTER_LANE_MASK_EN.
module fm_tile_router #(
    parameter int POX = 32,
    parameter int DW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set,
    input  logic [7:0]            k_set,
    input  logic [7:0]            stride_set,
    input  logic [7:0]            pad_set,
    input  logic [7:0]            ox_set,
    input  logic [7:0]            oy_set,
    input  logic [7:0]            ix_set,
    input  logic [7:0]            iy_set,
    input  logic                  start,
    output logic                  busy,
    output logic                  cfg_err,
    output logic                  rd_en,
    output logic [11:0]           rd_row,
    output logic [11:0]           rd_col,
    input  logic [2*POX*DW-1:0]   rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [POX*DW-1:0]     out_data,
    output logic                  out_first,
    output logic                  out_last_k,
    output logic                  out_last
`ifdef FM_ROUTER_LANE_MASK_EN
    ,
    output logic [POX-1:0]        out_mask
`endif
);

    localparam int unsigned POX_M1 = POX - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    state_t state_r, state_s;

    logic [7:0] cfg_k_r, cfg_stride_r, cfg_pad_r, cfg_ox_r, cfg_oy_r, cfg_ix_r, cfg_iy_r;
    logic       cfg_err_r;
    logic [7:0] oy_cnt_r, t_cnt_r, ky_cnt_r, kx_cnt_r;

    logic [POX*DW-1:0] out_data_r;
    logic              out_first_r, out_last_k_r, out_last_r;

    logic               start_ok_s, stride2_s, row_ok_s;
    logic               kx_last_s, ky_last_s, t_last_s, oy_last_s, beat_last_s;
    logic [9:0]         ntiles_s;
    logic [11:0]        tbase_s;
    logic signed [11:0] oy12_s, row_s, col_s, ix12_s;
    logic signed [11:0] lane_col_s [POX];
    logic [POX-1:0]     keep_s;
    logic [POX*DW-1:0]  lane_data_s;
    logic               busy_s, rd_en_s, out_valid_s;
    logic               unused_hi_s;

    // A never-loaded (k=0) configuration must not launch a walk either.
    assign start_ok_s = start && !cfg_err_r && (cfg_k_r != 8'd0);
    assign stride2_s  = (cfg_stride_r == 8'd2);
    assign ntiles_s   = 10'((10'(cfg_ox_r) + 10'(POX_M1)) / 10'(POX));

    assign kx_last_s   = (kx_cnt_r == cfg_k_r - 8'd1);
    assign ky_last_s   = (ky_cnt_r == cfg_k_r - 8'd1);
    assign t_last_s    = ({2'b00, t_cnt_r} == ntiles_s - 10'd1);
    assign oy_last_s   = (oy_cnt_r == cfg_oy_r - 8'd1);
    assign beat_last_s = kx_last_s && ky_last_s && t_last_s && oy_last_s;

    assign tbase_s  = 12'(t_cnt_r) * 12'(POX);
    assign oy12_s   = $signed({4'b0000, oy_cnt_r});
    assign ix12_s   = $signed({4'b0000, cfg_ix_r});
    assign row_s    = (stride2_s ? (oy12_s <<< 1) : oy12_s)
                    + $signed({4'b0000, ky_cnt_r}) - $signed({4'b0000, cfg_pad_r});
    assign col_s    = $signed(stride2_s ? (tbase_s << 1) : tbase_s)
                    + $signed({4'b0000, kx_cnt_r}) - $signed({4'b0000, cfg_pad_r});
    assign row_ok_s = !row_s[11] && (row_s < $signed({4'b0000, cfg_iy_r}));

    // The topmost pixel of the fetched segment is never selected at any stride.
    assign unused_hi_s = ^rd_data[2*POX*DW-1 -: DW];

    // Per-lane pixel selection and out-of-image / beyond-ox zeroing.
    always_comb begin
        lane_data_s = {(POX*DW){1'b0}};
        keep_s      = {POX{1'b0}};
        lane_col_s  = '{default: 12'sd0};
        for (int p = 0; p < POX; p++) begin
            lane_col_s[p] = col_s + $signed(stride2_s ? 12'(2 * p) : 12'(p));
            keep_s[p]     = !lane_col_s[p][11] && (lane_col_s[p] < ix12_s)
                          && ((tbase_s + 12'(p)) < {4'b0000, cfg_ox_r});
            if (keep_s[p]) begin
                if (stride2_s) begin
                    lane_data_s[p*DW +: DW] = rd_data[2*p*DW +: DW];
                end else begin
                    lane_data_s[p*DW +: DW] = rd_data[p*DW +: DW];
                end
            end else begin
                lane_data_s[p*DW +: DW] = {DW{1'b0}};
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_ok_s) state_s = S_FETCH;
                else            state_s = S_IDLE;
            end
            S_FETCH: begin
                if (row_ok_s) state_s = S_WAIT;
                else          state_s = S_EMIT;
            end
            S_WAIT: state_s = S_EMIT;
            S_EMIT: begin
                if (out_ready) begin
                    if (beat_last_s) state_s = S_IDLE;
                    else             state_s = S_FETCH;
                end else begin
                    state_s = S_EMIT;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode; rd_en/out_valid are suppressed during the reset cycle.
    always_comb begin
        busy_s      = 1'b0;
        rd_en_s     = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            S_IDLE:  busy_s = 1'b0;
            S_FETCH: begin
                busy_s  = 1'b1;
                rd_en_s = row_ok_s && !rst;
            end
            S_WAIT:  busy_s = 1'b1;
            S_EMIT: begin
                busy_s      = 1'b1;
                out_valid_s = !rst;
            end
            default: busy_s = 1'b0;
        endcase
    end

    // Configuration latch and validity flag, frozen while a walk runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_k_r      <= 8'd0;
            cfg_stride_r <= 8'd0;
            cfg_pad_r    <= 8'd0;
            cfg_ox_r     <= 8'd0;
            cfg_oy_r     <= 8'd0;
            cfg_ix_r     <= 8'd0;
            cfg_iy_r     <= 8'd0;
            cfg_err_r    <= 1'b0;
        end else if (set && (state_r == S_IDLE)) begin
            cfg_k_r      <= k_set;
            cfg_stride_r <= stride_set;
            cfg_pad_r    <= pad_set;
            cfg_ox_r     <= ox_set;
            cfg_oy_r     <= oy_set;
            cfg_ix_r     <= ix_set;
            cfg_iy_r     <= iy_set;
            cfg_err_r    <= ((stride_set != 8'd1) && (stride_set != 8'd2))
                         || (k_set == 8'd0) || (ox_set == 8'd0) || (oy_set == 8'd0);
        end else begin
            cfg_err_r    <= cfg_err_r;
        end
    end

    // Walk counters: kx fastest, then ky, tile, output row.
    always_ff @(posedge clk) begin
        if (rst) begin
            oy_cnt_r <= 8'd0;
            t_cnt_r  <= 8'd0;
            ky_cnt_r <= 8'd0;
            kx_cnt_r <= 8'd0;
        end else if ((state_r == S_IDLE) && start_ok_s) begin
            oy_cnt_r <= 8'd0;
            t_cnt_r  <= 8'd0;
            ky_cnt_r <= 8'd0;
            kx_cnt_r <= 8'd0;
        end else if ((state_r == S_EMIT) && out_ready) begin
            if (kx_last_s) begin
                kx_cnt_r <= 8'd0;
                if (ky_last_s) begin
                    ky_cnt_r <= 8'd0;
                    if (t_last_s) begin
                        t_cnt_r  <= 8'd0;
                        oy_cnt_r <= oy_cnt_r + 8'd1;
                    end else begin
                        t_cnt_r <= t_cnt_r + 8'd1;
                    end
                end else begin
                    ky_cnt_r <= ky_cnt_r + 8'd1;
                end
            end else begin
                kx_cnt_r <= kx_cnt_r + 8'd1;
            end
        end else begin
            kx_cnt_r <= kx_cnt_r;
        end
    end

    // Beat payload, loaded on entry to EMIT and held through any stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r   <= {(POX*DW){1'b0}};
            out_first_r  <= 1'b0;
            out_last_k_r <= 1'b0;
            out_last_r   <= 1'b0;
`ifdef FM_ROUTER_LANE_MASK_EN
            out_mask     <= {POX{1'b0}};
`endif
        end else if (((state_r == S_FETCH) && !row_ok_s) || (state_r == S_WAIT)) begin
            out_data_r   <= (state_r == S_WAIT) ? lane_data_s : {(POX*DW){1'b0}};
            out_first_r  <= (ky_cnt_r == 8'd0) && (kx_cnt_r == 8'd0);
            out_last_k_r <= ky_last_s && kx_last_s;
            out_last_r   <= beat_last_s;
`ifdef FM_ROUTER_LANE_MASK_EN
            out_mask     <= keep_s;
`endif
        end else begin
            out_data_r   <= out_data_r;
        end
    end

    assign busy       = busy_s;
    assign cfg_err    = cfg_err_r;
    assign rd_en      = rd_en_s;
    assign rd_row     = row_s;
    assign rd_col     = col_s;
    assign out_valid  = out_valid_s;
    assign out_data   = out_data_r;
    assign out_first  = out_first_r;
    assign out_last_k = out_last_k_r;
    assign out_last   = out_last_r;

endmodule

// File: tb/tb_fm_tile_router.sv
// Scoreboard bench for fm_tile_router (POX=4, DW=8): a loop-level reference
// model fills expected-beat and expected-read queues; a monitor pops and compares.
module tb_fm_tile_router;

    localparam int POX = 4;
    localparam int DW  = 8;

    logic                clk = 1'b0;
    logic                rst, set, start, out_ready;
    logic [7:0]          k_set, stride_set, pad_set, ox_set, oy_set, ix_set, iy_set;
    logic                busy, cfg_err, rd_en, out_valid, out_first, out_last_k, out_last;
    logic [11:0]         rd_row, rd_col;
    logic [2*POX*DW-1:0] rd_data;
    logic [POX*DW-1:0]   out_data;
    logic [POX-1:0]      out_mask;

    always #5 clk = ~clk;

    fm_tile_router #(.POX(POX), .DW(DW)) dut (
        .clk(clk), .rst(rst), .set(set),
        .k_set(k_set), .stride_set(stride_set), .pad_set(pad_set),
        .ox_set(ox_set), .oy_set(oy_set), .ix_set(ix_set), .iy_set(iy_set),
        .start(start), .busy(busy), .cfg_err(cfg_err),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_last_k(out_last_k), .out_last(out_last)
`ifdef FM_ROUTER_LANE_MASK_EN
        , .out_mask(out_mask)
`endif
    );

    typedef struct {
        logic [POX*DW-1:0] data;
        logic [POX-1:0]    mask;
        logic              first, lastk, last;
    } beat_t;
    typedef struct {
        logic [11:0] row, col;
    } rd_t;

    beat_t exp_q[$];
    rd_t   rd_q[$];
    beat_t eb;
    rd_t   er;

    int vec_cnt = 0, err_cnt = 0, hs_cnt = 0, busy_cycles = 0, stall_checks = 0;
    int exp_cycles = 0, n_model = 0, ready_mode = 0;
    int cur_k, cur_s, cur_pad, cur_ox, cur_oy, cur_ix, cur_iy;
    logic              prev_stall = 1'b0;
    logic [POX*DW-1:0] held_data;
    logic [2:0]        held_flags;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Row memory model: pixel j of the fetched segment is row*16 + (col+j) + 1.
    always @(posedge clk) begin
        if (rd_en) begin
            for (int j = 0; j < 2*POX; j++)
                rd_data[j*DW +: DW] <= DW'($signed(rd_row) * 16 + $signed(rd_col) + j + 1);
        end else begin
            rd_data <= {$urandom, $urandom};
        end
    end

    // out_ready driver: 0 always ready, 1 random, 2 five stall cycles per beat.
    initial begin
        int low;
        low = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (!out_valid) begin
                        out_ready = 1'b0; low = 0;
                    end else if (low < 5) begin
                        out_ready = 1'b0; low++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: read requests, stall stability and accepted beats.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cycles++;
            if (rd_en) begin
                check("rd_en_in_emit", {63'd0, out_valid}, 64'd0);
                if (rd_q.size() == 0) begin
                    vec_cnt++; err_cnt++;
                    $display("FAIL unexpected_rd: got row %0d col %0d, expected no read",
                             $signed(rd_row), $signed(rd_col));
                end else begin
                    er = rd_q.pop_front();
                    check("rd_row", {52'd0, rd_row}, {52'd0, er.row});
                    check("rd_col", {52'd0, rd_col}, {52'd0, er.col});
                end
            end
            if (prev_stall) begin
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                stall_checks++;
                check("stall_data", {32'd0, out_data}, {32'd0, held_data});
                check("stall_flags", {61'd0, out_first, out_last_k, out_last}, {61'd0, held_flags});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++; err_cnt++;
                    $display("FAIL unexpected_beat: got data %0h, expected no beat", out_data);
                end else begin
                    eb = exp_q.pop_front();
                    check("out_data", {32'd0, out_data}, {32'd0, eb.data});
                    check("out_flags", {61'd0, out_first, out_last_k, out_last},
                          {61'd0, eb.first, eb.lastk, eb.last});
`ifdef FM_ROUTER_LANE_MASK_EN
                    check("out_mask", {60'd0, out_mask}, {60'd0, eb.mask});
`endif
                end
                hs_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            held_data  = out_data;
            held_flags = {out_first, out_last_k, out_last};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_set(input int k, s, pad, ox, oy, ix, iy);
        @(posedge clk); #1;
        set = 1'b1;
        k_set = 8'(k); stride_set = 8'(s); pad_set = 8'(pad);
        ox_set = 8'(ox); oy_set = 8'(oy); ix_set = 8'(ix); iy_set = 8'(iy);
        cur_k = k; cur_s = s; cur_pad = pad; cur_ox = ox; cur_oy = oy; cur_ix = ix; cur_iy = iy;
        @(posedge clk); #1;
        set = 1'b0;
    endtask

    // Reference walk: every (oy, tile, ky, kx) yields one beat from plain index arithmetic.
    task automatic build_model();
        beat_t b;
        rd_t   r;
        int    tiles;
        tiles = (cur_ox + POX - 1) / POX;
        exp_cycles = 0;
        n_model = 0;
        for (int oyr = 0; oyr < cur_oy; oyr++)
            for (int t = 0; t < tiles; t++)
                for (int ky = 0; ky < cur_k; ky++)
                    for (int kx = 0; kx < cur_k; kx++) begin
                        int row, col;
                        bit rok;
                        row = oyr * cur_s + ky - cur_pad;
                        col = t * POX * cur_s + kx - cur_pad;
                        rok = (row >= 0) && (row < cur_iy);
                        b.data = '0;
                        b.mask = '0;
                        for (int p = 0; p < POX; p++) begin
                            int c, x;
                            c = col + p * cur_s;
                            x = t * POX + p;
                            b.mask[p] = (c >= 0) && (c < cur_ix) && (x < cur_ox);
                            if (b.mask[p] && rok) b.data[p*DW +: DW] = DW'(row * 16 + c + 1);
                        end
                        b.first = (ky == 0) && (kx == 0);
                        b.lastk = (ky == cur_k - 1) && (kx == cur_k - 1);
                        b.last  = b.lastk && (t == tiles - 1) && (oyr == cur_oy - 1);
                        exp_q.push_back(b);
                        if (rok) begin
                            r.row = 12'(row);
                            r.col = 12'(col);
                            rd_q.push_back(r);
                            exp_cycles += 3;
                        end else begin
                            exp_cycles += 2;
                        end
                        n_model++;
                    end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    // exp_beats < 0 means compare the accepted-beat count against the model only.
    task automatic run_walk(input int mode, input int exp_beats, input bit inject);
        int h0;
        ready_mode = mode;
        build_model();
        h0 = hs_cnt;
        busy_cycles = 0;
        stall_checks = 0;
        pulse_start();
        check("busy_after_start", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (inject && i == 7) begin
                set = 1'b1; stride_set = 8'd3; k_set = 8'd2; ox_set = 8'd1;
            end else if (inject && i == 8) begin
                set = 1'b0;
            end
            if (!busy && exp_q.size() == 0) break;
        end
        check("beats_left", 64'(exp_q.size()), 64'd0);
        check("reads_left", 64'(rd_q.size()), 64'd0);
        check("busy_end", {63'd0, busy}, 64'd0);
        check("beat_count", 64'(hs_cnt - h0), 64'(exp_beats < 0 ? n_model : exp_beats));
        if (mode == 0) check("walk_cycles", 64'(busy_cycles), 64'(exp_cycles));
        if (mode == 2) check("stall_cycles", 64'(stall_checks), 64'(5 * n_model));
        if (inject) check("set_ignored_busy", {63'd0, cfg_err}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int h0;
        rst = 1'b1; set = 1'b0; start = 1'b0;
        k_set = 8'd0; stride_set = 8'd0; pad_set = 8'd0;
        ox_set = 8'd0; oy_set = 8'd0; ix_set = 8'd0; iy_set = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_rd_en", {63'd0, rd_en}, 64'd0);
        check("rst_cfg_err", {63'd0, cfg_err}, 64'd0);
        check("rst_data", {32'd0, out_data}, 64'd0);
        check("rst_flags", {61'd0, out_first, out_last_k, out_last}, 64'd0);

        // 3x3 pad-1 walk over a 4x4 image: 36 beats with edge padding.
        do_set(3, 1, 1, 4, 4, 4, 4);
        check("cfg_ok", {63'd0, cfg_err}, 64'd0);
        run_walk(0, 36, 1'b0);

        // Stride 2, lanes pick every other pixel.
        do_set(1, 2, 0, 4, 4, 8, 8);
        run_walk(0, 4, 1'b0);

        // ox not a multiple of POX: second tile zeroes its upper lanes.
        do_set(1, 1, 0, 6, 1, 6, 6);
        run_walk(0, 2, 1'b0);

        // Five-cycle back-pressure on every beat.
        do_set(1, 2, 0, 4, 4, 8, 8);
        run_walk(2, 4, 1'b0);

        // Random back-pressure with an ignored mid-walk set.
        do_set(3, 1, 1, 4, 4, 4, 4);
        run_walk(1, 36, 1'b1);

        // Invalid stride flags an error and blocks start.
        do_set(3, 3, 1, 4, 4, 4, 4);
        @(negedge clk);
        check("cfg_err_stride3", {63'd0, cfg_err}, 64'd1);
        pulse_start();
        check("start_blocked", {63'd0, busy}, 64'd0);
        repeat (3) @(posedge clk);
        #1 check("still_idle", {63'd0, busy}, 64'd0);

        // Reset on beat 10, then a full restart.
        do_set(3, 1, 1, 4, 4, 4, 4);
        check("cfg_err_cleared", {63'd0, cfg_err}, 64'd0);
        ready_mode = 0;
        build_model();
        h0 = hs_cnt;
        pulse_start();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (out_valid && (hs_cnt - h0 == 10)) break;
        end
        check("abort_at_beat10", 64'(hs_cnt - h0), 64'd10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        rd_q.delete();
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_valid", {63'd0, out_valid}, 64'd0);
        check("abort_rd_en", {63'd0, rd_en}, 64'd0);
        check("abort_data", {32'd0, out_data}, 64'd0);
        repeat (4) @(posedge clk);
        #1 check("abort_idle", {63'd0, busy}, 64'd0);
        do_set(3, 1, 1, 4, 4, 4, 4);
        run_walk(0, 36, 1'b0);

        // Randomized configurations under random back-pressure.
        for (int n = 0; n < 6; n++) begin
            do_set($urandom_range(1, 3), $urandom_range(1, 2), $urandom_range(0, 2),
                   $urandom_range(1, 9), $urandom_range(1, 3),
                   $urandom_range(1, 12), $urandom_range(1, 12));
            run_walk(1, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
